fir_sample_pacer: RTL
=====================

// Module: fir_sample_pacer
// PURPOSE
// - Sample source on the fir_filter input side. Drives the fir_filter input protocol:
//   sample value + one-cycle valid pulse (input_data / input_data_flag).
// - Buffers host-written samples in a FIFO and emits them one per programmable
//   period. Replaces hand-timed stimulus and feeds the filter in-system.
// PARAMETERS
// - DATA_WIDTH  8   sample width; matches fir_filter input_data
// - DEPTH       16  FIFO entries; power of 2, >= 2
// - GAP_WIDTH   8   width of the gap field; idle cycles between flags
// PORTS
// - clk          in   1                 single clock; all logic on posedge
// - rst          in   1                 synchronous reset, active high
// - wr_data      in   DATA_WIDTH        sample to enqueue
// - wr_en        in   1                 enqueue strobe; accepted only if wr_full==0
// - wr_full      out  1                 FIFO full (registered)
// - wr_level     out  $clog2(DEPTH)+1   FIFO occupancy, 0..DEPTH
// - gap          in   GAP_WIDTH         flag period = gap+1 cycles; captured at start
// - start        in   1                 pulse; begins a run from IDLE
// - stop         in   1                 pulse; ends a run
// - busy         out  1                 high while FSM is not IDLE
// - input_data       out  DATA_WIDTH    sample to fir_filter; holds last emitted value
// - input_data_flag  out  1             one-cycle valid pulse to fir_filter
// - underrun     out  1                 one-cycle pulse: emission due, FIFO empty
// BEHAVIOUR
// - Reset:
//   - FSM=IDLE; FIFO emptied; gap register = 0.
//   - All outputs 0: wr_full, wr_level, busy, input_data, input_data_flag, underrun.
//   - Reset mid-run aborts the run immediately; queued samples are lost.
// - FIFO:
//   - Write accepted iff wr_en && !wr_full; a write while full is dropped silently.
//   - Pop happens only in EMIT.
//   - Write and pop in the same cycle: level unchanged, both take effect.
//   - Pointers wrap modulo DEPTH.
//   - wr_full/wr_level reflect the state after the current edge.
// - FSM: IDLE, EMIT, WAIT; cnt is GAP_WIDTH bits.
//   - IDLE:
//     - start && !stop && level>0 -> EMIT; latch gap into gap_r.
//     - start with level==0 -> stays IDLE, no flag, no underrun.
//   - EMIT (1 cycle):
//     - input_data_flag=1; input_data <= FIFO head; pop.
//     - Latency: start at edge N -> flag high in cycle N+1.
//     - stop in this cycle: emission still completes, next=IDLE.
//     - else gap_r>0: next=WAIT, cnt=gap_r-1.
//     - else gap_r==0: next=EMIT if level after pop >0; else underrun pulse, IDLE.
//   - WAIT:
//     - input_data_flag=0.
//     - stop -> IDLE next edge, no flag.
//     - cnt>0: cnt--.
//     - cnt==0: next=EMIT if level>0; else underrun=1 for 1 cycle, next=IDLE.
// - Simultaneous events and held values:
//   - start while busy is ignored; stop and start together: stop wins.
//   - gap changes during a run are ignored until the next start.
//   - input_data holds its value between flags; it is only updated in EMIT.
//   - Samples left in the FIFO after stop stay queued for the next start.
// CONFIGURATION
// - FIR_PACER_COUNT_EN defined:
//   - Adds output sample_count [15:0] = number of input_data_flag pulses since rst.
//   - Wraps 0xFFFF -> 0x0000; reset value 0; not cleared by stop.
// - FIR_PACER_COUNT_EN undefined: port and counter are absent; all else identical.
// TESTING
// - 1. Paced run: write 17, 18; gap=9; start.
//   - flag with 17 one cycle after start; flag with 18 ten cycles later.
//   - underrun ten cycles after that; busy falls with it.
// - 2. Back-to-back: gap=0; write 1, 2, 3, 4; start.
//   - Four consecutive flag cycles with data 1, 2, 3, 4, then underrun.
//   - input_data stays 4 afterwards.
// - 3. FIFO full: write 16 samples with no start.
//   - wr_full=1, wr_level=16; 17th write dropped.
//   - A later run emits exactly the first 16 values in order.
// - 4. Stop: write 5 samples; gap=3; stop asserted in the WAIT after the 2nd flag.
//   - No further flag; busy=0 next cycle; wr_level=3.
//   - Restart emits 3rd-5th samples.
// - 5. Reset mid-run: rst during WAIT with 4 queued.
//   - All outputs 0 after the next edge, wr_level=0.
//   - A start with no writes produces no flag.
// - 6. FIR_PACER_COUNT_EN defined: scenario 2 -> sample_count=4.
//   - Preload counter to 0xFFFE by 2 extra flags beyond wrap: count wraps to 0x0000 correctly.

Source files
------------

// File: rtl/fir_sample_pacer.sv
// Sample source for the fir_filter input side: a host-written FIFO drained one
// sample per (gap+1) cycles as input_data + input_data_flag. Optional FIR_PACER_COUNT_EN adds sample_count.
module fir_sample_pacer #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int GAP_WIDTH  = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [DATA_WIDTH-1:0]        wr_data,
  input  logic                         wr_en,
  output logic                         wr_full,
  output logic [$clog2(DEPTH):0]       wr_level,
  input  logic [GAP_WIDTH-1:0]         gap,
  input  logic                         start,
  input  logic                         stop,
  output logic                         busy,
  output logic [DATA_WIDTH-1:0]        input_data,
  output logic                         input_data_flag,
`ifdef FIR_PACER_COUNT_EN
  output logic [15:0]                  sample_count,
`endif
  output logic                         underrun
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [1:0] {S_IDLE, S_EMIT, S_WAIT} state_t;

  state_t                state, state_next;
  logic [GAP_WIDTH-1:0]  cnt, cnt_next, gap_r;
  logic                  gap_load, underrun_next;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic [LW-1:0]         level_next;
  logic [DATA_WIDTH-1:0] last_r;
  logic                  push, pop;

  assign push = wr_en && !wr_full;
  assign pop  = (state == S_EMIT);

  always_comb begin
    level_next = wr_level;
    if (push && !pop)      level_next = wr_level + LW'(1);
    else if (!push && pop) level_next = wr_level - LW'(1);
  end

  // Emission decisions use the post-edge occupancy, so a sample written in the
  // same cycle already counts as available for the next EMIT.
  always_comb begin
    state_next    = state;
    cnt_next      = cnt;
    gap_load      = 1'b0;
    underrun_next = 1'b0;
    case (state)
      S_IDLE: begin
        if (start && !stop && level_next != '0) begin
          state_next = S_EMIT;
          gap_load   = 1'b1;
        end
      end
      S_EMIT: begin
        if (stop) begin
          state_next = S_IDLE;
        end else if (gap_r != '0) begin
          state_next = S_WAIT;
          cnt_next   = gap_r - GAP_WIDTH'(1);
        end else if (level_next != '0) begin
          state_next = S_EMIT;
        end else begin
          state_next    = S_IDLE;
          underrun_next = 1'b1;
        end
      end
      S_WAIT: begin
        if (stop) begin
          state_next = S_IDLE;
        end else if (cnt != '0) begin
          cnt_next = cnt - GAP_WIDTH'(1);
        end else if (level_next != '0) begin
          state_next = S_EMIT;
        end else begin
          state_next    = S_IDLE;
          underrun_next = 1'b1;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      gap_r    <= '0;
      underrun <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      wr_level <= '0;
      wr_full  <= 1'b0;
      last_r   <= '0;
    end else begin
      state    <= state_next;
      cnt      <= cnt_next;
      underrun <= underrun_next;
      if (gap_load) gap_r <= gap;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
        last_r <= mem[rd_ptr];
      end
      wr_level <= level_next;
      wr_full  <= (level_next == LW'(DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  // The head is presented during the flag cycle itself; last_r holds it afterwards.
  assign input_data_flag = (state == S_EMIT);
  assign input_data      = input_data_flag ? mem[rd_ptr] : last_r;
  assign busy            = (state != S_IDLE);

`ifdef FIR_PACER_COUNT_EN
  always_ff @(posedge clk) begin
    if (rst)      sample_count <= '0;
    else if (pop) sample_count <= sample_count + 16'd1;
  end
`endif

endmodule
